// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: default TAP parameters and the 16-state TAP encoding.
package jtag_pkg;

  localparam int unsigned IR_WIDTH_DEF   = 4;
  localparam int unsigned IDCODE_WIDTH   = 32;
  localparam logic [3:0]  IDCODE_IR_DEF  = 4'h1;
  localparam logic [3:0]  BYPASS_IR_DEF  = 4'hF;
  localparam logic [31:0] IDCODE_VAL_DEF = 32'h1BEEF001;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_ctrl_fsm_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register and TMS-driven next-state logic.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic          tck,
  input  logic          trst,
  input  logic          tms,
  output tap_ctrl_fsm_t state_o
);

  tap_ctrl_fsm_t state_q, state_d;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= TEST_LOGIC_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
  end

  always_comb begin
    state_o = state_q;
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, BYPASS and IDCODE registers, user-DR strobes and the
// falling-edge TDO mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0]         IDCODE_VAL = IDCODE_VAL_DEF,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(IDCODE_IR_DEF),
  parameter logic [IR_WIDTH-1:0] BYPASS_IR  = {IR_WIDTH{1'b1}}
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output tap_ctrl_fsm_t       tap_state_o,
  output logic [IR_WIDTH-1:0] ir_o,
  output logic                dr_user_sel_o,
  output logic                dr_capture_o,
  output logic                dr_shift_o,
  output logic                dr_update_o,
  input  logic                user_tdo_i
);

  tap_ctrl_fsm_t state;

  logic [IR_WIDTH-1:0]     ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [IDCODE_WIDTH-1:0] idc_q, idc_d;
  logic                    byp_q, byp_d;
  logic                    tdo_q, tdo_d, oe_q, oe_d;
  logic                    sel_idcode, sel_bypass;

  jtag_tap_fsm u_fsm (
    .tck     (tck),
    .trst    (trst),
    .tms     (tms),
    .state_o (state)
  );

  assign sel_idcode = (ir_q == IDCODE_IR);
  assign sel_bypass = (ir_q == BYPASS_IR);

  // Capture/shift/update act on the rising edge that leaves the state.
  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    idc_d   = idc_q;
    byp_d   = byp_q;
    case (state)
      TEST_LOGIC_RESET: ir_d    = IDCODE_IR;
      CAPTURE_IR:       ir_sr_d = IR_WIDTH'(2'b01);
      SHIFT_IR:         ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPDATE_IR:        ir_d    = ir_sr_q;
      CAPTURE_DR: begin
        if (sel_idcode) idc_d = IDCODE_VAL;
        if (sel_bypass) byp_d = 1'b0;
      end
      SHIFT_DR: begin
        if (sel_idcode) idc_d = {tdi, idc_q[IDCODE_WIDTH-1:1]};
        if (sel_bypass) byp_d = tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_q    <= IDCODE_IR;
      ir_sr_q <= '0;
      idc_q   <= IDCODE_VAL;
      byp_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      idc_q   <= idc_d;
      byp_q   <= byp_d;
    end
  end

  // TDO holds its last value outside the shift states.
  always_comb begin
    tdo_d = tdo_q;
    oe_d  = 1'b0;
    case (state)
      SHIFT_IR: begin
        tdo_d = ir_sr_q[0];
        oe_d  = 1'b1;
      end
      SHIFT_DR: begin
        oe_d = 1'b1;
        if (sel_idcode)      tdo_d = idc_q[0];
        else if (sel_bypass) tdo_d = byp_q;
        else                 tdo_d = user_tdo_i;
      end
      default: ;
    endcase
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      tdo_q <= tdo_d;
      oe_q  <= oe_d;
    end
  end

  assign tdo           = tdo_q;
  assign tdo_oe        = oe_q;
  assign tap_state_o   = state;
  assign ir_o          = ir_q;
  assign dr_user_sel_o = !sel_idcode && !sel_bypass;
  assign dr_capture_o  = (state == CAPTURE_DR) && dr_user_sel_o;
  assign dr_shift_o    = (state == SHIFT_DR)   && dr_user_sel_o;
  assign dr_update_o   = (state == UPDATE_DR)  && dr_user_sel_o;

endmodule
